// File: rtl/wb_interconnect_n.sv
// One-master to N-slave Wishbone classic interconnect with address decode,
// per-transaction slave latching, bus-error generation and fault recording.
module wb_interconnect_n #(
  parameter int unsigned WB_DATA_WIDTH  = 32,
  parameter int unsigned WB_ADDR_WIDTH  = 32,
  parameter int unsigned WB_SEL_WIDTH   = 4,
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000},
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [WB_ADDR_WIDTH-1:0]            wb_m_addr_i,
  input  logic [WB_DATA_WIDTH-1:0]            wb_m_data_i,
  input  logic                                wb_m_we_i,
  input  logic [WB_SEL_WIDTH-1:0]             wb_m_sel_i,
  input  logic                                wb_m_stb_i,
  input  logic                                wb_m_cyc_i,
  output logic                                wb_m_ack_o,
  output logic                                wb_m_err_o,
  output logic [WB_DATA_WIDTH-1:0]            wb_m_data_o,
  output logic [WB_ADDR_WIDTH-1:0]            wb_s_addr_o,
  output logic [WB_DATA_WIDTH-1:0]            wb_s_data_o,
  output logic                                wb_s_we_o,
  output logic [WB_SEL_WIDTH-1:0]             wb_s_sel_o,
  output logic [NUM_SLAVES-1:0]               wb_s_stb_o,
  output logic [NUM_SLAVES-1:0]               wb_s_cyc_o,
  input  logic [NUM_SLAVES-1:0]               wb_s_ack_i,
  input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0] wb_s_data_i,
  output logic [1:0]                          fault_code_o,
  output logic [WB_ADDR_WIDTH-1:0]            fault_addr_o,
  input  logic                                fault_clr_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                     r_state, w_state_nxt;
  logic [NUM_SLAVES-1:0]      r_sel;
  logic [TO_W-1:0]            r_cnt;
  logic [1:0]                 r_fault_code;
  logic [WB_ADDR_WIDTH-1:0]   r_fault_addr;

  logic                       w_req;
  logic [NUM_SLAVES-1:0]      w_hit_oh;
  logic                       w_any_hit;
  logic                       w_sel_ack;
  logic [WB_DATA_WIDTH-1:0]   w_sel_data;
  logic                       w_to_hit;
  logic                       w_miss_fault;
  logic                       w_to_fault;

  assign w_req = wb_m_cyc_i & wb_m_stb_i;

  assign wb_s_addr_o = wb_m_addr_i;
  assign wb_s_data_o = wb_m_data_i;
  assign wb_s_we_o   = wb_m_we_i;
  assign wb_s_sel_o  = wb_m_sel_i;

  // Lowest-index hit wins when windows overlap.
  always_comb begin
    w_hit_oh  = '0;
    w_any_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!w_any_hit &&
          ((wb_m_addr_i & SLAVE_MASK[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) ==
           SLAVE_BASE[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH])) begin
        w_hit_oh[i] = 1'b1;
        w_any_hit   = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel[i]) w_sel_data = w_sel_data | wb_s_data_i[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
    end
  end

  assign w_sel_ack    = (r_state == S_BUSY) && w_req && ((r_sel & wb_s_ack_i) != '0);
  assign w_to_hit     = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
  assign w_miss_fault = (r_state == S_IDLE) && w_req && !w_any_hit;
  assign w_to_fault   = (r_state == S_BUSY) && wb_m_cyc_i && !w_sel_ack && w_to_hit;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_req && w_any_hit) begin
        r_sel <= w_hit_oh;
        r_cnt <= '0;
      end else if (r_state == S_BUSY && wb_m_cyc_i && !w_sel_ack && !w_to_hit &&
                   r_cnt != '1) begin
        r_cnt <= r_cnt + TO_W'(1);
      end
    end
  end

  // A fault raised in the same cycle as a clear request is kept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fault_code <= 2'b00;
      r_fault_addr <= '0;
    end else if (w_miss_fault) begin
      r_fault_code <= 2'b01;
      r_fault_addr <= wb_m_addr_i;
    end else if (w_to_fault) begin
      r_fault_code <= 2'b10;
      r_fault_addr <= wb_m_addr_i;
    end else if (fault_clr_i) begin
      r_fault_code <= 2'b00;
      r_fault_addr <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_state_nxt = w_any_hit ? S_BUSY : S_ERR;
      S_BUSY: begin
        if (!wb_m_cyc_i)    w_state_nxt = S_IDLE;
        else if (w_sel_ack) w_state_nxt = S_IDLE;
        else if (w_to_hit)  w_state_nxt = S_ERR;
      end
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    wb_s_stb_o  = '0;
    wb_s_cyc_o  = '0;
    wb_m_ack_o  = 1'b0;
    wb_m_err_o  = 1'b0;
    wb_m_data_o = '0;
    case (r_state)
      S_BUSY: begin
        if (w_req) begin
          wb_s_stb_o = r_sel;
          wb_s_cyc_o = r_sel;
        end
        wb_m_ack_o  = w_sel_ack;
        wb_m_data_o = w_sel_data;
      end
      S_ERR:   wb_m_err_o = 1'b1;
      default: ;
    endcase
  end

  assign fault_code_o = r_fault_code;
  assign fault_addr_o = r_fault_addr;

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Directed bench for wb_interconnect_n: decode, miss, timeout, overlap, abort,
// asynchronous reset and fault-register priority.
module tb_wb_interconnect_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  m_addr, m_wdata, m_rdata, s_addr, s_wdata, f_addr;
  logic         m_we, m_stb, m_cyc, m_ack, m_err, s_we, f_clr;
  logic [3:0]   m_sel, s_sel, s_stb, s_cyc, s_ack, ack_en, ack_force;
  logic [127:0] s_rdata;
  logic [1:0]   f_code;
  int           n_cmp = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  assign s_rdata = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_AAAA};
  assign s_ack   = (s_stb & ack_en) | ack_force;

  wb_interconnect_n #(
    .NUM_SLAVES     (4),
    .SLAVE_BASE     ({32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h4000_0000}),
    .SLAVE_MASK     ({32'hE000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT_CYCLES (8),
    .TO_W           (8)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_m_addr_i(m_addr), .wb_m_data_i(m_wdata), .wb_m_we_i(m_we), .wb_m_sel_i(m_sel),
    .wb_m_stb_i(m_stb), .wb_m_cyc_i(m_cyc), .wb_m_ack_o(m_ack), .wb_m_err_o(m_err),
    .wb_m_data_o(m_rdata), .wb_s_addr_o(s_addr), .wb_s_data_o(s_wdata), .wb_s_we_o(s_we),
    .wb_s_sel_o(s_sel), .wb_s_stb_o(s_stb), .wb_s_cyc_o(s_cyc), .wb_s_ack_i(s_ack),
    .wb_s_data_i(s_rdata), .fault_code_o(f_code), .fault_addr_o(f_addr), .fault_clr_i(f_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic [31:0] d);
    m_addr = a; m_we = we; m_wdata = d; m_cyc = 1'b1; m_stb = 1'b1;
  endtask

  task automatic drop();
    m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; m_addr = '0; m_wdata = '0; m_we = 1'b0; m_sel = 4'hF;
    m_stb = 1'b0; m_cyc = 1'b0; f_clr = 1'b0; ack_en = '0; ack_force = '0;
    #1;
    chk("rst_stb", s_stb, 0); chk("rst_cyc", s_cyc, 0); chk("rst_ack", m_ack, 0);
    chk("rst_err", m_err, 0); chk("rst_fcode", f_code, 0); chk("rst_faddr", f_addr, 0);
    @(negedge clk); rst_n = 1'b1;

    // zero-wait read of slave 2, then back-to-back with stb held
    @(negedge clk); req(32'h2000_0010, 1'b0, 32'h0); ack_en = 4'b0100;
    #1 chk("rd_c0_stb", s_stb, 0); chk("rd_bcast_addr", s_addr, 32'h2000_0010);
    @(negedge clk); #1;
    chk("rd_c1_stb", s_stb, 4'b0100); chk("rd_c1_cyc", s_cyc, 4'b0100);
    chk("rd_c1_ack", m_ack, 1); chk("rd_c1_data", m_rdata, 32'hDEAD_BEEF); chk("rd_c1_err", m_err, 0);
    @(negedge clk); #1 chk("b2b_idle_stb", s_stb, 0); chk("b2b_idle_ack", m_ack, 0);
    @(negedge clk); #1 chk("b2b_stb", s_stb, 4'b0100); chk("b2b_ack", m_ack, 1);
    drop();
    @(negedge clk); #1 chk("rd_done_stb", s_stb, 0);

    // unmapped write
    @(negedge clk); req(32'h9000_0000, 1'b1, 32'h1234_5678);
    #1 chk("miss_c0_stb", s_stb, 0); chk("miss_bcast_data", s_wdata, 32'h1234_5678);
    chk("miss_bcast_we", s_we, 1);
    @(negedge clk); #1;
    chk("miss_err", m_err, 1); chk("miss_stb", s_stb, 0); chk("miss_ack", m_ack, 0);
    chk("miss_fcode", f_code, 2'b01); chk("miss_faddr", f_addr, 32'h9000_0000);
    drop();
    @(negedge clk); #1 chk("miss_err_1cyc", m_err, 0);

    // timeout on slave 1
    @(negedge clk); req(32'h1000_0004, 1'b0, 32'h0); ack_en = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); #1 chk("to_busy_stb", s_stb, 4'b0010); chk("to_busy_err", m_err, 0);
    end
    @(negedge clk); #1;
    chk("to_err", m_err, 1); chk("to_err_stb", s_stb, 0); chk("to_ack", m_ack, 0);
    chk("to_fcode", f_code, 2'b10); chk("to_faddr", f_addr, 32'h1000_0004);
    drop();
    @(negedge clk); #1 chk("to_err_1cyc", m_err, 0);

    // master abort mid-BUSY
    @(negedge clk); req(32'h1000_0008, 1'b0, 32'h0);
    @(negedge clk); #1 chk("abort_c1_stb", s_stb, 4'b0010);
    drop();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1 chk("abort_err", m_err, 0); chk("abort_ack", m_ack, 0);
    end
    chk("abort_fcode", f_code, 2'b10); chk("abort_faddr", f_addr, 32'h1000_0004);

    // overlapping windows: slave 0 wins, spurious ack from slave 3 ignored
    @(negedge clk); req(32'h4000_0100, 1'b0, 32'h0); ack_force = 4'b1000;
    #1 chk("ovl_c0_ack", m_ack, 0);
    @(negedge clk); #1;
    chk("ovl_stb", s_stb, 4'b0001); chk("ovl_spur_ack", m_ack, 0);
    chk("ovl_data", m_rdata, 32'h0000_AAAA);
    ack_force = 4'b0001;
    #1 chk("ovl_ack", m_ack, 1); chk("ovl_err", m_err, 0);
    @(negedge clk); drop(); ack_force = '0;
    #1 chk("ovl_done_stb", s_stb, 0);

    // slave 3 reachable through its wider window
    @(negedge clk); req(32'h5000_0000, 1'b0, 32'h0); ack_en = 4'b1000;
    @(negedge clk); #1;
    chk("s3_stb", s_stb, 4'b1000); chk("s3_ack", m_ack, 1); chk("s3_data", m_rdata, 32'h3333_3333);
    drop(); ack_en = '0;

    // asynchronous reset mid-BUSY
    @(negedge clk); req(32'h2000_0000, 1'b0, 32'h0);
    @(negedge clk); #1 chk("rst_busy_stb", s_stb, 4'b0100);
    ack_force = 4'b0100;
    #1 chk("rst_busy_ack", m_ack, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_stb", s_stb, 0); chk("arst_cyc", s_cyc, 0); chk("arst_ack", m_ack, 0);
    chk("arst_err", m_err, 0); chk("arst_fcode", f_code, 0);
    @(negedge clk); drop(); ack_force = '0; rst_n = 1'b1;

    // fault recorded in the same cycle as clear
    @(negedge clk); req(32'hA000_0000, 1'b0, 32'h0); f_clr = 1'b1;
    @(negedge clk); #1;
    chk("clrpri_err", m_err, 1); chk("clrpri_fcode", f_code, 2'b01);
    chk("clrpri_faddr", f_addr, 32'hA000_0000);
    drop(); f_clr = 1'b0;

    // ack in the same cycle as timeout
    @(negedge clk); req(32'h1000_0020, 1'b0, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk); #1 chk("tack_busy_ack", m_ack, 0);
    end
    @(negedge clk); ack_force = 4'b0010;
    #1 chk("tack_ack", m_ack, 1); chk("tack_err_c8", m_err, 0);
    @(negedge clk); drop(); ack_force = '0;
    #1;
    chk("tack_err", m_err, 0); chk("tack_fcode", f_code, 2'b01);
    chk("tack_faddr", f_addr, 32'hA000_0000);

    // plain clear
    @(negedge clk); f_clr = 1'b1;
    @(negedge clk); f_clr = 1'b0;
    #1 chk("clr_fcode", f_code, 0); chk("clr_faddr", f_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
